// File: rtl/blink_pkg.sv
// ============================================================================
// blink_pkg: shared rate limits, FSM state type and one-hot helper
// Rev 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

  localparam logic [3:0] RATE_MIN = 4'b0001;
  localparam logic [3:0] RATE_MAX = 4'b1000;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_rate_controller_tick_prescaler.sv
// ============================================================================
// tick_prescaler: emits a one-cycle tick every TICK_DIV cycles while running
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = run && (r_cnt == CW'(TICK_DIV - 1));

  // Held at zero while stopped so a restart always begins a full tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || !run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/blink_rate_controller.sv
// ============================================================================
// blink_rate_controller: button-driven one-hot rate select and LED blink timer
// Rev 1.0
// ============================================================================
`default_nettype none

module blink_rate_controller
  import blink_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int BASE_PERIOD = 2,
  parameter int LOAD_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              shift_left,
  input  logic              shift_right,
  output logic [3:0]        rate_onehot,
  output logic [LOAD_W-1:0] load_value,
  output logic              expire,
  output logic              out_light
);

  state_t            r_state;
  logic              r_left_q;
  logic              r_right_q;
  logic [3:0]        r_rate;
  logic [LOAD_W-1:0] r_count;
  logic              r_light;
  logic              r_expire;

  logic              w_press_l;
  logic              w_press_r;
  logic              w_shift_up;
  logic              w_shift_dn;
  logic              w_rate_change;
  logic [3:0]        w_next_rate;
  logic [LOAD_W-1:0] w_next_load;
  logic              w_tick;

  assign w_press_l = shift_left & ~r_left_q;
  assign w_press_r = shift_right & ~r_right_q;

  // Simultaneous edges cancel; presses at a limit are dropped entirely
  assign w_shift_up    = w_press_l & ~w_press_r & (r_rate != RATE_MAX);
  assign w_shift_dn    = w_press_r & ~w_press_l & (r_rate != RATE_MIN);
  assign w_rate_change = w_shift_up | w_shift_dn;

  always_comb begin
    w_next_rate = r_rate;
    if (w_shift_up) begin
      w_next_rate = r_rate << 1;
    end else if (w_shift_dn) begin
      w_next_rate = r_rate >> 1;
    end
  end

  assign w_next_load = LOAD_W'(BASE_PERIOD) << onehot_to_idx(w_next_rate);
  assign load_value  = LOAD_W'(BASE_PERIOD) << onehot_to_idx(r_rate);
  assign rate_onehot = r_rate;
  assign out_light   = r_light;
  assign expire      = r_expire;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (w_rate_change || !enable),
    .run   (r_state == RUN),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
      r_rate    <= RATE_MIN;
    end else begin
      r_left_q  <= shift_left;
      r_right_q <= shift_right;
      r_rate    <= w_next_rate;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= STOP;
      r_count  <= LOAD_W'(BASE_PERIOD - 1);
      r_light  <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      case (r_state)
        STOP: begin
          r_light <= 1'b0;
          r_count <= w_next_load - LOAD_W'(1);
          if (enable) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= STOP;
            r_light <= 1'b0;
            r_count <= w_next_load - LOAD_W'(1);
          end else if (w_tick && (r_count == '0)) begin
            // Expiry wins over a coincident rate change, which still sets the reload
            r_light  <= ~r_light;
            r_expire <= 1'b1;
            r_count  <= w_next_load - LOAD_W'(1);
          end else if (w_rate_change) begin
            r_count <= w_next_load - LOAD_W'(1);
          end else if (w_tick) begin
            r_count <= r_count - LOAD_W'(1);
          end
        end
        default: r_state <= STOP;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blink_rate_controller.sv
// Directed bench for blink_rate_controller with TICK_DIV=1, BASE_PERIOD=2, LOAD_W=8.
`default_nettype none

module tb_blink_rate_controller;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       shift_left;
  logic       shift_right;
  logic [3:0] rate_onehot;
  logic [7:0] load_value;
  logic       expire;
  logic       out_light;

  int pass_cnt;
  int total_cnt;

  blink_rate_controller #(
    .TICK_DIV    (1),
    .BASE_PERIOD (2),
    .LOAD_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .rate_onehot (rate_onehot),
    .load_value  (load_value),
    .expire      (expire),
    .out_light   (out_light)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until expire is seen; n is the number of steps taken, -1 on timeout
  task automatic wait_expire(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (expire === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; shift_left = 1'b0; shift_right = 1'b0;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (rate_onehot !== 4'b0001) $display("FAIL reset_rate: got %b expected 0001", rate_onehot); else pass_cnt++;
    total_cnt++; if (load_value !== 8'd2) $display("FAIL reset_load: got %0d expected 2", load_value); else pass_cnt++;
    total_cnt++; if (out_light !== 1'b0) $display("FAIL reset_light: got %b expected 0", out_light); else pass_cnt++;
    total_cnt++; if (expire !== 1'b0) $display("FAIL reset_expire: got %b expected 0", expire); else pass_cnt++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_enable();
    logic [7:0] light_exp;
    logic [7:0] exp_exp;
    light_exp = 8'b1100_1100;
    exp_exp   = 8'b0101_0100;
    enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      total_cnt++; if (out_light !== light_exp[c-1]) $display("FAIL enable_light c%0d: got %b expected %b", c, out_light, light_exp[c-1]); else pass_cnt++;
      total_cnt++; if (expire !== exp_exp[c-1]) $display("FAIL enable_expire c%0d: got %b expected %b", c, expire, exp_exp[c-1]); else pass_cnt++;
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_rate [3];
    logic [7:0] exp_load [3];
    int n;
    exp_rate = '{4'b0010, 4'b0100, 4'b1000};
    exp_load = '{8'd4, 8'd8, 8'd16};
    for (int i = 0; i < 3; i++) begin
      step();
      shift_left = 1'b1;
      step();
      shift_left = 1'b0;
      total_cnt++; if (rate_onehot !== exp_rate[i]) $display("FAIL left_rate%0d: got %b expected %b", i, rate_onehot, exp_rate[i]); else pass_cnt++;
      total_cnt++; if (load_value !== exp_load[i]) $display("FAIL left_load%0d: got %0d expected %0d", i, load_value, exp_load[i]); else pass_cnt++;
    end
    step();
    shift_left = 1'b1;
    wait_expire(40, n);
    shift_left = 1'b0;
    total_cnt++; if (n + 1 !== 16) $display("FAIL left_sat_period: got %0d expected 16", n + 1); else pass_cnt++;
    total_cnt++; if (rate_onehot !== 4'b1000) $display("FAIL left_sat_rate: got %b expected 1000", rate_onehot); else pass_cnt++;
    total_cnt++; if (load_value !== 8'd16) $display("FAIL left_sat_load: got %0d expected 16", load_value); else pass_cnt++;
    wait_expire(40, n);
    total_cnt++; if (n !== 16) $display("FAIL left_period16: got %0d expected 16", n); else pass_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; shift_left = 1'b0; shift_right = 1'b0;
    #2;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_shift_right();
    int n;
    do_reset();
    enable = 1'b1;
    step();
    shift_right = 1'b1;
    step();
    shift_right = 1'b0;
    total_cnt++; if (rate_onehot !== 4'b0001) $display("FAIL right_min_rate: got %b expected 0001", rate_onehot); else pass_cnt++;
    total_cnt++; if (load_value !== 8'd2) $display("FAIL right_min_load: got %0d expected 2", load_value); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      shift_left = 1'b1;
      step();
      shift_left = 1'b0;
    end
    total_cnt++; if (rate_onehot !== 4'b0100) $display("FAIL right_setup_rate: got %b expected 0100", rate_onehot); else pass_cnt++;
    step();
    shift_right = 1'b1;
    step();
    shift_right = 1'b0;
    total_cnt++; if (rate_onehot !== 4'b0010) $display("FAIL right_rate: got %b expected 0010", rate_onehot); else pass_cnt++;
    total_cnt++; if (load_value !== 8'd4) $display("FAIL right_load: got %0d expected 4", load_value); else pass_cnt++;
    wait_expire(20, n);
    total_cnt++; if (n !== 4) $display("FAIL right_next_toggle: got %0d expected 4", n); else pass_cnt++;
  endtask

  task automatic test_both_and_hold();
    int n;
    wait_expire(20, n);
    step();
    shift_left = 1'b1;
    shift_right = 1'b1;
    wait_expire(20, n);
    total_cnt++; if (n + 1 !== 4) $display("FAIL both_no_reload: got %0d expected 4", n + 1); else pass_cnt++;
    total_cnt++; if (rate_onehot !== 4'b0010) $display("FAIL both_rate: got %b expected 0010", rate_onehot); else pass_cnt++;
    shift_left = 1'b0;
    shift_right = 1'b0;
    step();
    shift_left = 1'b1;
    repeat (6) step();
    total_cnt++; if (rate_onehot !== 4'b0100) $display("FAIL hold_rate: got %b expected 0100", rate_onehot); else pass_cnt++;
    total_cnt++; if (load_value !== 8'd8) $display("FAIL hold_load: got %0d expected 8", load_value); else pass_cnt++;
    shift_left = 1'b0;
  endtask

  task automatic test_coincident();
    int n;
    logic lt;
    wait_expire(40, n);
    repeat (7) step();
    lt = out_light;
    shift_right = 1'b1;
    step();
    shift_right = 1'b0;
    total_cnt++; if (expire !== 1'b1) $display("FAIL coin_expire: got %b expected 1", expire); else pass_cnt++;
    total_cnt++; if (out_light !== ~lt) $display("FAIL coin_light: got %b expected %b", out_light, ~lt); else pass_cnt++;
    total_cnt++; if (rate_onehot !== 4'b0010) $display("FAIL coin_rate: got %b expected 0010", rate_onehot); else pass_cnt++;
    wait_expire(20, n);
    total_cnt++; if (n !== 4) $display("FAIL coin_next_period: got %0d expected 4", n); else pass_cnt++;
  endtask

  task automatic test_stop();
    int n;
    wait_expire(20, n);
    if (out_light !== 1'b1) wait_expire(20, n);
    total_cnt++; if (out_light !== 1'b1) $display("FAIL stop_setup_light: got %b expected 1", out_light); else pass_cnt++;
    step();
    enable = 1'b0;
    step();
    total_cnt++; if (out_light !== 1'b0) $display("FAIL stop_light: got %b expected 0", out_light); else pass_cnt++;
    total_cnt++; if (expire !== 1'b0) $display("FAIL stop_expire: got %b expected 0", expire); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (out_light !== 1'b0) $display("FAIL stop_hold_light: got %b expected 0", out_light); else pass_cnt++;
    enable = 1'b1;
    wait_expire(20, n);
    total_cnt++; if (n !== 5) $display("FAIL restart_period: got %0d expected 5", n); else pass_cnt++;
    total_cnt++; if (out_light !== 1'b1) $display("FAIL restart_light: got %b expected 1", out_light); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    step();
    shift_left = 1'b1;
    step();
    shift_left = 1'b0;
    repeat (3) step();
    #3 rst = 1'b0;
    #1;
    total_cnt++; if (rate_onehot !== 4'b0001) $display("FAIL arst_rate: got %b expected 0001", rate_onehot); else pass_cnt++;
    total_cnt++; if (load_value !== 8'd2) $display("FAIL arst_load: got %0d expected 2", load_value); else pass_cnt++;
    total_cnt++; if (out_light !== 1'b0) $display("FAIL arst_light: got %b expected 0", out_light); else pass_cnt++;
    total_cnt++; if (expire !== 1'b0) $display("FAIL arst_expire: got %b expected 0", expire); else pass_cnt++;
    step();
    rst = 1'b1;
    enable = 1'b1;
    wait_expire(20, n);
    total_cnt++; if (n !== 3) $display("FAIL arst_restart: got %0d expected 3", n); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_enable();
    test_shift_left();
    test_shift_right();
    test_both_and_hold();
    test_coincident();
    test_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/blink_rate_controller.md
# blink_rate_controller

Sequencing controller for the programmable blinker datapath. It turns button presses into a saturating one-hot rate selection and maps that selection to a half-period load value. A prescaled countdown timer drives the toggling light output, and the block reloads the timer cleanly whenever the rate changes or the blinker is stopped. It sits between the board push-buttons/enable switch and the LED.

## Interface

Parameters:
- TICK_DIV, default 1000: clock cycles per timer tick; must be ≥ 1.
- BASE_PERIOD, default 2: half-period in ticks at the fastest rate; must be ≥ 1.
- LOAD_W, default 8: load value and counter width; BASE_PERIOD<<3 must fit.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  run request; level, synchronous to clk.
- shift_left  in  1  slow-down button; level, debounced upstream, synchronous.
- shift_right  in  1  speed-up button; level, debounced upstream, synchronous.
- rate_onehot  out  4  current rate selection, one-hot.
- load_value  out  LOAD_W  current half-period in ticks.
- expire  out  1  one-cycle pulse, high in the cycle out_light changes.
- out_light  out  1  blinker output.

## Operation

- Press detection: each button is registered once. A press is a rising edge (btn & ~btn_q).
- If both buttons have a rising edge in the same cycle, neither is accepted.
- Rate: a left press shifts rate_onehot toward bit 3; a right press shifts it toward bit 0. Both saturate at 4'b1000 and 4'b0001. A press at a limit is a no-op: no reload, no other side effect.
- load_value = BASE_PERIOD << index, where index is the position of the set bit in rate_onehot (0..3).
- FSM with two states:
  - STOP → RUN when enable=1.
  - RUN → STOP when enable=0.
  - In STOP: out_light=0, prescaler=0, count=load_value-1, expire=0. Rate presses are still accepted.
- Prescaler: counts 0..TICK_DIV-1 in RUN. tick is high when prescaler==TICK_DIV-1; the prescaler then wraps to 0.
- Countdown: on tick, if count==0 then toggle out_light, pulse expire, and reload count=load_value-1; otherwise decrement. One half-period is therefore exactly load_value ticks.
- Accepted rate change in RUN: the prescaler is cleared to 0 and count is reloaded to the new load_value-1. out_light holds its current phase (no forced toggle).
- Rate change coincident with expiry: the toggle and expire pulse still occur, and count loads the new value-1.

## Timing

- Reset values (asserted asynchronously, take effect immediately): state=STOP, rate_onehot=4'b0001, load_value=BASE_PERIOD, count=BASE_PERIOD-1, prescaler=0, out_light=0, expire=0, button registers=0.
- enable sampled high in cycle n: RUN from n+1, prescaler counts from n+1, first toggle visible in cycle n+1+load_value*TICK_DIV.
- Subsequent toggles follow every load_value*TICK_DIV cycles.
- Press edge in cycle m: rate_onehot, load_value, count and prescaler are updated in m+1. The next toggle is load_value*TICK_DIV cycles after m+1.
- enable low in cycle k: state is STOP and out_light=0 from k+1. A later re-enable always starts a full half-period.
- expire and out_light are registered and change on the same edge.
- Reset deasserted mid-operation: the block restarts from the reset values. No partial state is retained.

## Structure

- Shared package blink_pkg holds:
  - RATE_MIN=4'b0001 and RATE_MAX=4'b1000.
  - the FSM state typedef (STOP, RUN).
  - a one-hot-to-index function.
- One sub-module, tick_prescaler (clk, rst, clear, run → tick). It is reusable by the other blinker-lab blocks.
- Rate register, countdown and toggle logic stay in the top module.

## Test plan

All scenarios use TICK_DIV=1, BASE_PERIOD=2, LOAD_W=8.

- Reset, then enable=1 at cycle 0 → out_light 0 until cycle 3, then toggles every 2 cycles; expire pulses with each toggle.
- Three shift_left presses → rate_onehot 0010/0100/1000, load_value 4/8/16. Fourth press → no change and no reload (period stays 16).
- shift_right press at 4'b0001 → no change. Press from 4'b0100 → 4'b0010, and the next toggle comes 4 cycles later.
- shift_left and shift_right rising in the same cycle → rate_onehot unchanged, no reload. Held buttons produce no repeated shifts.
- Press in the same cycle count reaches 0 → toggle occurs and the following half-period uses the new load_value.
- enable dropped mid-period → out_light=0 next cycle; re-enable gives a full new half-period. rst pulsed low mid-count → all outputs at reset values immediately, without waiting for a clk edge.
